instruction_decode: RTL and testbench

- Decode stage of a single-cycle LEGv8 (64-bit ARM subset) CPU.
- Takes the fetched 32-bit instruction and its PC, and produces the control signals, register operands and extended immediate.
- Resolves branches: returns pc_src and branch_address so fetch selects PC+4 or the branch target before its next update.
- Contains the 32x64 register file, written back from later stages.

---
 rtl/legv8_pkg.sv | 46 ++++
 rtl/instruction_decode_if.sv | 38 +++
 rtl/instruction_decode_register_file.sv | 36 +++
 rtl/instruction_decode.sv | 103 ++++++++++
 tb/tb_instruction_decode.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: datapath width, opcode patterns, ALU op encodings,
// and the control bundle produced by the decode stage.
package legv8_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  // 11-bit opcodes, instruction[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_HALT = 11'b11111111111;
  // 10-bit opcodes, instruction[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  // 8-bit opcode, instruction[31:24]
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  // 6-bit opcode, instruction[31:26]
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,  // address calculation for loads/stores
    ALU_PASS = 2'b01,  // pass-through / zero test for CBZ
    ALU_FUNC = 2'b10   // operation selected by opcode function bits
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_D, IMM_I, IMM_CB, IMM_B
  } imm_kind_e;

  typedef struct packed {
    logic    reg2loc;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    uncond_branch;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/instruction_decode_if.sv
// Decode-stage bus: fetched instruction/PC and write-back port in, control,
// operands, immediate and branch resolution out.
//   master : fetch/write-back side (drives instruction, pc, wb_*)
//   slave  : decode stage
interface instruction_decode_if;
  import legv8_pkg::*;

  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            wb_reg_write;
  logic [4:0]      wb_write_reg;
  logic [XLEN-1:0] wb_write_data;

  logic            pc_src;
  logic [XLEN-1:0] branch_address;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic [XLEN-1:0] sign_ext_imm;
  logic [4:0]      write_reg;
  logic            reg2loc, alu_src, mem_to_reg, reg_write;
  logic            mem_read, mem_write, branch, uncond_branch;
  logic [1:0]      alu_op;
  logic            halt;

  modport master (
    output instruction, pc, wb_reg_write, wb_write_reg, wb_write_data,
    input  pc_src, branch_address, read_data1, read_data2, sign_ext_imm,
           write_reg, reg2loc, alu_src, mem_to_reg, reg_write, mem_read,
           mem_write, branch, uncond_branch, alu_op, halt
  );

  modport slave (
    input  instruction, pc, wb_reg_write, wb_write_reg, wb_write_data,
    output pc_src, branch_address, read_data1, read_data2, sign_ext_imm,
           write_reg, reg2loc, alu_src, mem_to_reg, reg_write, mem_read,
           mem_write, branch, uncond_branch, alu_op, halt
  );
endinterface

// File: rtl/instruction_decode_register_file.sv
// 32x64 register file: two combinational read ports, one write port.
// Register NREGS-1 (XZR) always reads 0 and ignores writes. Synchronous
// active-high reset clears all registers. No write-to-read bypass.
//   ra1/ra2 -> rd1/rd2 : read ports
//   we/wa/wd           : write port, committed at posedge clk
module register_file
  import legv8_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int NR = NREGS,
  localparam int AW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd
);
  localparam logic [AW-1:0] XZR = AW'(NR - 1);

  logic [NR-1:0][W-1:0] regs;

  always_ff @(posedge clk) begin
    if (reset)
      regs <= '0;
    else if (we && (wa != XZR))
      regs[wa] <= wd;
  end

  assign rd1 = (ra1 == XZR) ? '0 : regs[ra1];
  assign rd2 = (ra2 == XZR) ? '0 : regs[ra2];
endmodule

// File: rtl/instruction_decode.sv
// LEGv8 single-cycle decode stage: control decode, immediate extension,
// register file access and branch resolution (all combinational except the
// register file write).
//   clk, reset : clock and synchronous active-high reset
//   dif        : decode bus (slave side)
module instruction_decode
  import legv8_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  instruction_decode_if.slave dif
);
  logic [31:0] ins;
  ctrl_t       ctrl;
  imm_kind_e   imm_kind;
  logic [XLEN-1:0] imm, rd2;
  logic [4:0]  ra2;

  assign ins = dif.instruction;

  // Priority by pattern width: 11-bit first, then 10, 8, 6. HALT and unknown
  // opcodes fall out as the all-zero NOP control word.
  always_comb begin
    ctrl     = '0;
    imm_kind = IMM_NONE;
    if (ins[31:21] == OP_ADD || ins[31:21] == OP_SUB ||
        ins[31:21] == OP_AND || ins[31:21] == OP_ORR) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_op    = ALU_FUNC;
    end else if (ins[31:21] == OP_LDUR) begin
      ctrl.alu_src    = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg_write  = 1'b1;
      ctrl.mem_read   = 1'b1;
      imm_kind        = IMM_D;
    end else if (ins[31:21] == OP_STUR) begin
      ctrl.reg2loc   = 1'b1;
      ctrl.alu_src   = 1'b1;
      ctrl.mem_write = 1'b1;
      imm_kind       = IMM_D;
    end else if (ins[31:21] == OP_HALT) begin
      ctrl = '0;
    end else if (ins[31:22] == OP_ADDI || ins[31:22] == OP_SUBI) begin
      ctrl.alu_src   = 1'b1;
      ctrl.reg_write = 1'b1;
      ctrl.alu_op    = ALU_FUNC;
      imm_kind       = IMM_I;
    end else if (ins[31:24] == OP_CBZ) begin
      ctrl.reg2loc = 1'b1;
      ctrl.branch  = 1'b1;
      ctrl.alu_op  = ALU_PASS;
      imm_kind     = IMM_CB;
    end else if (ins[31:26] == OP_B) begin
      ctrl.uncond_branch = 1'b1;
      imm_kind           = IMM_B;
    end
  end

  always_comb begin
    imm = '0;
    case (imm_kind)
      IMM_D:   imm = XLEN'($signed(ins[20:12]));
      IMM_I:   imm = XLEN'(ins[21:10]);
      IMM_CB:  imm = XLEN'($signed(ins[23:5]));
      IMM_B:   imm = XLEN'($signed(ins[25:0]));
      default: imm = '0;
    endcase
  end

  // Stores and CBZ read Rt (the [4:0] field) through port 2.
  assign ra2 = ctrl.reg2loc ? ins[4:0] : ins[20:16];

  register_file #(.W(XLEN), .NR(NREGS)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (ins[9:5]),
    .ra2   (ra2),
    .rd1   (dif.read_data1),
    .rd2   (rd2),
    .we    (dif.wb_reg_write),
    .wa    (dif.wb_write_reg),
    .wd    (dif.wb_write_data)
  );

  assign dif.read_data2     = rd2;
  assign dif.sign_ext_imm   = imm;
  assign dif.branch_address = dif.pc + (imm << 2);
  // CBZ is resolved here so fetch can redirect before its next update.
  assign dif.pc_src = !reset &&
                      (ctrl.uncond_branch || (ctrl.branch && (rd2 == '0)));
  assign dif.write_reg      = ins[4:0];
  assign dif.halt           = (ins[31:21] == OP_HALT);

  assign dif.reg2loc       = ctrl.reg2loc;
  assign dif.alu_src       = ctrl.alu_src;
  assign dif.mem_to_reg    = ctrl.mem_to_reg;
  assign dif.reg_write     = ctrl.reg_write;
  assign dif.mem_read      = ctrl.mem_read;
  assign dif.mem_write     = ctrl.mem_write;
  assign dif.branch        = ctrl.branch;
  assign dif.uncond_branch = ctrl.uncond_branch;
  assign dif.alu_op        = ctrl.alu_op;
endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode controls, immediates,
// branch resolution, register file write/read, XZR and reset behaviour.
module tb_instruction_decode;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  instruction_decode_if dif ();
  instruction_decode dut (.clk(clk), .reset(reset), .dif(dif));

  always #5 clk = ~clk;

  // {reg2loc,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,uncond,alu_op}
  function automatic logic [9:0] ctl();
    return {dif.reg2loc, dif.alu_src, dif.mem_to_reg, dif.reg_write,
            dif.mem_read, dif.mem_write, dif.branch, dif.uncond_branch,
            dif.alu_op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    dif.wb_reg_write  = 1'b1;
    dif.wb_write_reg  = r;
    dif.wb_write_data = d;
    tick();
    dif.wb_reg_write  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dif.instruction = 32'h17FFFFFE;  // B -2: would branch if not in reset
    dif.pc = 64'h20;
    #1;
    checks++; if (dif.pc_src !== 1'b0) begin errors++;
      $display("FAIL reset_pc_src got %0b exp 0", dif.pc_src); end
    tick();
    reset = 1'b0;
    dif.instruction = 32'h8B030041;  // ADD X1,X2,X3
    #1;
    checks++; if (dif.read_data1 !== 64'h0 || dif.read_data2 !== 64'h0) begin errors++;
      $display("FAIL reset_regs got %h/%h exp 0/0", dif.read_data1, dif.read_data2); end
  endtask

  task automatic test_add();
    dif.instruction = 32'h8B030041;
    dif.pc = 64'h0;
    #1;
    checks++; if (ctl() !== 10'b0001000010) begin errors++;
      $display("FAIL add_ctrl got %b exp 0001000010", ctl()); end
    checks++; if (dif.pc_src !== 1'b0 || dif.write_reg !== 5'd1 || dif.halt !== 1'b0) begin errors++;
      $display("FAIL add_misc got pc_src=%0b wr=%0d halt=%0b exp 0/1/0", dif.pc_src, dif.write_reg, dif.halt); end
    checks++; if (dif.sign_ext_imm !== 64'h0) begin errors++;
      $display("FAIL add_imm got %h exp 0", dif.sign_ext_imm); end
  endtask

  task automatic test_cbz();
    wb(5'd5, 64'd7);
    dif.instruction = 32'hB4000065;  // CBZ X5, imm19=3
    dif.pc = 64'h8;
    #1;
    checks++; if (ctl() !== 10'b1000001001) begin errors++;
      $display("FAIL cbz_ctrl got %b exp 1000001001", ctl()); end
    checks++; if (dif.read_data2 !== 64'd7 || dif.pc_src !== 1'b0) begin errors++;
      $display("FAIL cbz_nz got rd2=%h pc_src=%0b exp 7/0", dif.read_data2, dif.pc_src); end
    checks++; if (dif.branch_address !== 64'h14) begin errors++;
      $display("FAIL cbz_target got %h exp 14", dif.branch_address); end
    wb(5'd5, 64'd0);
    checks++; if (dif.pc_src !== 1'b1) begin errors++;
      $display("FAIL cbz_zero got %0b exp 1", dif.pc_src); end
    dif.instruction = 32'hB400001F;  // CBZ XZR, imm19=0
    dif.pc = 64'h100;
    #1;
    checks++; if (dif.pc_src !== 1'b1 || dif.branch_address !== 64'h100) begin errors++;
      $display("FAIL cbz_xzr got pc_src=%0b tgt=%h exp 1/100", dif.pc_src, dif.branch_address); end
  endtask

  task automatic test_branch();
    dif.instruction = 32'h17FFFFFE;  // B -2
    dif.pc = 64'h20;
    #1;
    checks++; if (ctl() !== 10'b0000000100 || dif.pc_src !== 1'b1) begin errors++;
      $display("FAIL b_ctrl got %b pc_src=%0b exp 0000000100/1", ctl(), dif.pc_src); end
    checks++; if (dif.branch_address !== 64'h18 || dif.sign_ext_imm !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++;
      $display("FAIL b_back got tgt=%h imm=%h exp 18/fffffffffffffffe", dif.branch_address, dif.sign_ext_imm); end
    dif.instruction = 32'h17FFFFFC;  // B -4 from 0x10 wraps to 0
    dif.pc = 64'h10;
    #1;
    checks++; if (dif.branch_address !== 64'h0) begin errors++;
      $display("FAIL b_wrap got %h exp 0", dif.branch_address); end
  endtask

  task automatic test_mem();
    wb(5'd1, 64'hDEAD_BEEF);
    dif.instruction = 32'hF85F8041;  // LDUR X1,[X2,#-8]
    #1;
    checks++; if (ctl() !== 10'b0111100000) begin errors++;
      $display("FAIL ldur_ctrl got %b exp 0111100000", ctl()); end
    checks++; if (dif.sign_ext_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++;
      $display("FAIL ldur_imm got %h exp fffffffffffffff8", dif.sign_ext_imm); end
    dif.instruction = 32'hF81F8041;  // STUR X1,[X2,#-8]
    #1;
    checks++; if (ctl() !== 10'b1100010000) begin errors++;
      $display("FAIL stur_ctrl got %b exp 1100010000", ctl()); end
    checks++; if (dif.read_data2 !== 64'hDEAD_BEEF) begin errors++;
      $display("FAIL stur_rt got %h exp deadbeef", dif.read_data2); end
  endtask

  task automatic test_imm_halt();
    dif.instruction = 32'h913FFC41;  // ADDI X1,X2,#0xFFF
    #1;
    checks++; if (ctl() !== 10'b0101000010 || dif.sign_ext_imm !== 64'hFFF) begin errors++;
      $display("FAIL addi got ctl=%b imm=%h exp 0101000010/fff", ctl(), dif.sign_ext_imm); end
    dif.instruction = 32'hD1000C41;  // SUBI X1,X2,#3
    #1;
    checks++; if (ctl() !== 10'b0101000010 || dif.sign_ext_imm !== 64'h3) begin errors++;
      $display("FAIL subi got ctl=%b imm=%h exp 0101000010/3", ctl(), dif.sign_ext_imm); end
    dif.instruction = 32'hFFE00000;  // HALT
    #1;
    checks++; if (dif.halt !== 1'b1 || ctl() !== 10'b0 || dif.pc_src !== 1'b0) begin errors++;
      $display("FAIL halt got halt=%0b ctl=%b pc_src=%0b exp 1/0/0", dif.halt, ctl(), dif.pc_src); end
    dif.instruction = 32'h00000000;  // unknown opcode
    #1;
    checks++; if (ctl() !== 10'b0 || dif.halt !== 1'b0 || dif.sign_ext_imm !== 64'h0) begin errors++;
      $display("FAIL nop got ctl=%b halt=%0b imm=%h exp 0/0/0", ctl(), dif.halt, dif.sign_ext_imm); end
  endtask

  task automatic test_regfile();
    wb(5'd31, 64'd5);
    dif.instruction = 32'h8B1F03E0;  // ADD X0,XZR,XZR
    #1;
    checks++; if (dif.read_data1 !== 64'h0 || dif.read_data2 !== 64'h0) begin errors++;
      $display("FAIL xzr got %h/%h exp 0/0", dif.read_data1, dif.read_data2); end
    // Same-cycle write must not be visible until after the edge.
    dif.instruction = 32'h8B050041;  // ADD X1,X2,X5
    dif.wb_reg_write = 1'b1; dif.wb_write_reg = 5'd2; dif.wb_write_data = 64'h1234;
    #1;
    checks++; if (dif.read_data1 !== 64'h0) begin errors++;
      $display("FAIL no_bypass got %h exp 0", dif.read_data1); end
    tick();
    dif.wb_reg_write = 1'b0;
    #1;
    checks++; if (dif.read_data1 !== 64'h1234) begin errors++;
      $display("FAIL wr_x2 got %h exp 1234", dif.read_data1); end
  endtask

  task automatic test_midrun_reset();
    wb(5'd5, 64'hAA);
    reset = 1'b1;
    dif.wb_reg_write = 1'b1; dif.wb_write_reg = 5'd7; dif.wb_write_data = 64'd9;
    dif.instruction = 32'h17FFFFFE;
    dif.pc = 64'h40;
    #1;
    checks++; if (dif.pc_src !== 1'b0) begin errors++;
      $display("FAIL rst_pc_src got %0b exp 0", dif.pc_src); end
    tick();
    reset = 1'b0;
    dif.wb_reg_write = 1'b0;
    dif.instruction = 32'h8B050041;  // reads X2, X5
    #1;
    checks++; if (dif.read_data1 !== 64'h0 || dif.read_data2 !== 64'h0) begin errors++;
      $display("FAIL rst_clear got %h/%h exp 0/0", dif.read_data1, dif.read_data2); end
    dif.instruction = 32'h8B1F00E1;  // reads X7
    #1;
    checks++; if (dif.read_data1 !== 64'h0) begin errors++;
      $display("FAIL rst_wr_suppress got %h exp 0", dif.read_data1); end
    dif.instruction = 32'h17FFFFFE;
    #1;
    checks++; if (dif.pc_src !== 1'b1 || dif.branch_address !== 64'h38) begin errors++;
      $display("FAIL post_rst_b got pc_src=%0b tgt=%h exp 1/38", dif.pc_src, dif.branch_address); end
  endtask

  initial begin
    reset = 1'b1;
    dif.instruction = 32'h0;
    dif.pc = 64'h0;
    dif.wb_reg_write = 1'b0;
    dif.wb_write_reg = 5'd0;
    dif.wb_write_data = 64'h0;
    test_reset();
    test_add();
    test_cbz();
    test_branch();
    test_mem();
    test_imm_halt();
    test_regfile();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
